// File: rtl/stopwatch_timer_ctrl.sv
// stopwatch_timer_ctrl: mode controller for the stopwatch / countdown-timer board.
// Turns four debounced button levels into press events, classifies btn_start as a short or
// long press, sequences both blocks through run/pause/clear, selects which block's digits
// drive the display, and drives the mode and alarm LEDs.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   btn_mode          toggle stopwatch <-> timer
//   btn_start         short press = start/pause, long press = clear
//   btn_sel, btn_inc  timer digit select / increment (timer set mode only)
//   tmr_times_up      countdown reached zero
//   sw_d, tmr_d       eight BCD digits from the stopwatch / timer
//   sw_en, sw_clr     stopwatch enable, 1-cycle clear
//   tmr_en, tmr_rst   timer enable, 1-cycle reset (held high during rst)
//   tmr_digit_inc     1-cycle digit increment
//   tmr_digit_toggle  1-cycle digit select advance
//   disp_d            digits routed to the 7-segment display
//   mode_led          1 in timer mode
//   alarm_led         blinks while the timer alarm is active
module stopwatch_timer_ctrl #(
    parameter int unsigned HOLD_CYCLES  = 100_000_000,
    parameter int unsigned ALARM_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_start,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic        tmr_times_up,
    input  logic [31:0] sw_d,
    input  logic [31:0] tmr_d,
    output logic        sw_en,
    output logic        sw_clr,
    output logic        tmr_en,
    output logic        tmr_rst,
    output logic        tmr_digit_inc,
    output logic        tmr_digit_toggle,
    output logic [31:0] disp_d,
    output logic        mode_led,
    output logic        alarm_led
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

    localparam logic [2:0] SW_IDLE   = 3'd0;
    localparam logic [2:0] SW_RUN    = 3'd1;
    localparam logic [2:0] SW_PAUSE  = 3'd2;
    localparam logic [2:0] TMR_SET   = 3'd3;
    localparam logic [2:0] TMR_RUN   = 3'd4;
    localparam logic [2:0] TMR_PAUSE = 3'd5;
    localparam logic [2:0] TMR_DONE  = 3'd6;

    logic [2:0]    state_q, state_d;
    logic          prev_mode_q, prev_start_q, prev_sel_q, prev_inc_q;
    logic          armed_q, armed_d, armed_now;
    logic [HW-1:0] hold_q, hold_d;
    logic [AW-1:0] blink_q, blink_d;
    logic          sw_held_q, sw_held_d;
    logic          alarm_d, sw_clr_d, tmr_rst_d, inc_d, tog_d;
    logic          press_mode, press_sel, press_inc, start_rise;
    logic          short_ev, long_ev;

    function automatic logic is_tmr(input logic [2:0] s);
        return (s >= TMR_SET);
    endfunction

    assign press_mode = btn_mode & ~prev_mode_q;
    assign press_sel  = btn_sel & ~prev_sel_q;
    assign press_inc  = btn_inc & ~prev_inc_q;
    assign start_rise = btn_start & ~prev_start_q;

    // A hold only qualifies as a press if its rising edge was seen after reset; this keeps a
    // button held through reset release from producing either a long or a short event.
    assign armed_now = armed_q | start_rise;
    assign long_ev   = btn_start & armed_now & (hold_q == HW'(HOLD_CYCLES - 1));
    assign short_ev  = ~btn_start & prev_start_q & armed_q & (hold_q < HW'(HOLD_CYCLES));

    always_comb begin
        hold_d  = hold_q;
        armed_d = armed_q;
        if (!btn_start) begin
            hold_d  = '0;
            armed_d = 1'b0;
        end else begin
            if (hold_q < HW'(HOLD_CYCLES)) hold_d = hold_q + 1'b1;
            // Disarm once the long event fires so the release is silent.
            armed_d = armed_now & ~long_ev;
        end
    end

    always_comb begin
        state_d   = state_q;
        sw_held_d = sw_held_q;
        alarm_d   = alarm_led;
        blink_d   = blink_q;
        sw_clr_d  = 1'b0;
        tmr_rst_d = 1'b0;
        inc_d     = 1'b0;
        tog_d     = 1'b0;
        case (state_q)
            SW_IDLE: begin
                if (short_ev)        state_d  = SW_RUN;
                else if (long_ev)    sw_clr_d = 1'b1;
                else if (press_mode) state_d  = TMR_SET;
            end
            SW_RUN: begin
                if (short_ev) state_d = SW_PAUSE;
                else if (long_ev) begin
                    sw_clr_d = 1'b1;
                    state_d  = SW_IDLE;
                end
            end
            SW_PAUSE: begin
                if (short_ev) state_d = SW_RUN;
                else if (long_ev) begin
                    sw_clr_d = 1'b1;
                    state_d  = SW_IDLE;
                end else if (press_mode) begin
                    sw_held_d = 1'b1;
                    state_d   = TMR_SET;
                end
            end
            TMR_SET: begin
                if (short_ev)     state_d   = TMR_RUN;
                else if (long_ev) tmr_rst_d = 1'b1;
                else if (press_mode) begin
                    state_d   = sw_held_q ? SW_PAUSE : SW_IDLE;
                    sw_held_d = 1'b0;
                end
                else if (press_sel) tog_d = 1'b1;
                else if (press_inc) inc_d = 1'b1;
            end
            TMR_RUN: begin
                if (tmr_times_up) begin
                    state_d = TMR_DONE;
                    alarm_d = 1'b1;
                    blink_d = '0;
                end else if (short_ev) state_d = TMR_PAUSE;
                else if (long_ev) begin
                    tmr_rst_d = 1'b1;
                    state_d   = TMR_SET;
                end
            end
            TMR_PAUSE: begin
                if (short_ev) state_d = TMR_RUN;
                else if (long_ev) begin
                    tmr_rst_d = 1'b1;
                    state_d   = TMR_SET;
                end
            end
            TMR_DONE: begin
                if (short_ev || long_ev) begin
                    tmr_rst_d = 1'b1;
                    alarm_d   = 1'b0;
                    blink_d   = '0;
                    state_d   = TMR_SET;
                end else if (blink_q == AW'(ALARM_CYCLES - 1)) begin
                    alarm_d = ~alarm_led;
                    blink_d = '0;
                end else begin
                    blink_d = blink_q + 1'b1;
                end
            end
            default: state_d = SW_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= SW_IDLE;
            prev_mode_q      <= 1'b1;
            prev_start_q     <= 1'b1;
            prev_sel_q       <= 1'b1;
            prev_inc_q       <= 1'b1;
            armed_q          <= 1'b0;
            hold_q           <= '0;
            blink_q          <= '0;
            sw_held_q        <= 1'b0;
            sw_en            <= 1'b0;
            sw_clr           <= 1'b0;
            tmr_en           <= 1'b0;
            tmr_rst          <= 1'b1;
            tmr_digit_inc    <= 1'b0;
            tmr_digit_toggle <= 1'b0;
            disp_d           <= 32'hAAAA_AAAA;
            mode_led         <= 1'b0;
            alarm_led        <= 1'b0;
        end else begin
            state_q          <= state_d;
            prev_mode_q      <= btn_mode;
            prev_start_q     <= btn_start;
            prev_sel_q       <= btn_sel;
            prev_inc_q       <= btn_inc;
            armed_q          <= armed_d;
            hold_q           <= hold_d;
            blink_q          <= blink_d;
            sw_held_q        <= sw_held_d;
            sw_en            <= (state_d == SW_RUN);
            sw_clr           <= sw_clr_d;
            tmr_en           <= (state_d == TMR_RUN);
            tmr_rst          <= tmr_rst_d;
            tmr_digit_inc    <= inc_d;
            tmr_digit_toggle <= tog_d;
            // Follows the registered state, so it lags mode_led by one cycle.
            disp_d           <= is_tmr(state_q) ? tmr_d : sw_d;
            mode_led         <= is_tmr(state_d);
            alarm_led        <= alarm_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// Directed bench for stopwatch_timer_ctrl with HOLD_CYCLES = 8, ALARM_CYCLES = 4.
module tb_stopwatch_timer_ctrl;

    localparam logic [31:0] SW_DIG  = 32'h1234_5678;
    localparam logic [31:0] TMR_DIG = 32'h8765_4321;
    localparam logic [31:0] BLANK   = 32'hAAAA_AAAA;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_mode = 1'b0, btn_start = 1'b0, btn_sel = 1'b0, btn_inc = 1'b0;
    logic        tmr_times_up = 1'b0;
    logic [31:0] sw_d = SW_DIG, tmr_d = TMR_DIG;
    logic        sw_en, sw_clr, tmr_en, tmr_rst, tmr_digit_inc, tmr_digit_toggle;
    logic [31:0] disp_d;
    logic        mode_led, alarm_led;

    int tests = 0;
    int fails = 0;

    // Pulse counters and width-violation counter, sampled on the falling edge.
    int tog_cnt = 0, inc_cnt = 0, clr_cnt = 0, wide_cnt = 0;
    logic tog_p = 1'b0, inc_p = 1'b0, clr_p = 1'b0;

    stopwatch_timer_ctrl #(
        .HOLD_CYCLES (8),
        .ALARM_CYCLES(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .btn_mode        (btn_mode),
        .btn_start       (btn_start),
        .btn_sel         (btn_sel),
        .btn_inc         (btn_inc),
        .tmr_times_up    (tmr_times_up),
        .sw_d            (sw_d),
        .tmr_d           (tmr_d),
        .sw_en           (sw_en),
        .sw_clr          (sw_clr),
        .tmr_en          (tmr_en),
        .tmr_rst         (tmr_rst),
        .tmr_digit_inc   (tmr_digit_inc),
        .tmr_digit_toggle(tmr_digit_toggle),
        .disp_d          (disp_d),
        .mode_led        (mode_led),
        .alarm_led       (alarm_led)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            tog_cnt <= tog_cnt + int'(tmr_digit_toggle);
            inc_cnt <= inc_cnt + int'(tmr_digit_inc);
            clr_cnt <= clr_cnt + int'(sw_clr);
            if ((tmr_digit_toggle && tog_p) || (tmr_digit_inc && inc_p) || (sw_clr && clr_p))
                wide_cnt <= wide_cnt + 1;
        end
        tog_p <= tmr_digit_toggle;
        inc_p <= tmr_digit_inc;
        clr_p <= sw_clr;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic short_press();
        btn_start = 1'b1;
        tick(3);
        btn_start = 1'b0;
        tick(1);
    endtask

    task automatic pulse_btn(input int which);
        case (which)
            0: btn_mode = 1'b1;
            1: btn_sel  = 1'b1;
            default: btn_inc = 1'b1;
        endcase
        tick(1);
        btn_mode = 1'b0;
        btn_sel  = 1'b0;
        btn_inc  = 1'b0;
        tick(1);
    endtask

    logic [15:0] alarm_seq;
    int          t0, i0, c0;

    initial begin
        // Reset values
        rst = 1'b1;
        tick(3);
        chk("rst_tmr_rst", tmr_rst, 1);
        chk("rst_disp", disp_d, BLANK);
        chk("rst_sw_en", sw_en, 0);
        chk("rst_mode_led", mode_led, 0);
        chk("rst_alarm", alarm_led, 0);
        rst = 1'b0;
        tick(1);
        chk("post_rst_tmr_rst", tmr_rst, 0);
        chk("post_rst_disp", disp_d, SW_DIG);

        // Short press: IDLE -> RUN -> PAUSE
        btn_start = 1'b1;
        tick(3);
        chk("short_before_release", sw_en, 0);
        btn_start = 1'b0;
        tick(1);
        chk("short_run", sw_en, 1);
        short_press();
        chk("short_pause", sw_en, 0);
        short_press();
        chk("short_run_again", sw_en, 1);

        // Long press in RUN: clear on the 8th high cycle, silent release
        btn_start = 1'b1;
        tick(7);
        chk("long_clr_early", sw_clr, 0);
        chk("long_en_early", sw_en, 1);
        tick(1);
        chk("long_clr", sw_clr, 1);
        chk("long_en_off", sw_en, 0);
        tick(1);
        chk("long_clr_one_cycle", sw_clr, 0);
        tick(3);
        btn_start = 1'b0;
        tick(1);
        chk("long_release_en", sw_en, 0);
        chk("long_release_clr", sw_clr, 0);

        // To SW_PAUSE, then mode round trip
        short_press();
        short_press();
        chk("pause_again", sw_en, 0);
        btn_mode = 1'b1;
        tick(1);
        chk("mode_led_on", mode_led, 1);
        chk("disp_lags", disp_d, SW_DIG);
        btn_mode = 1'b0;
        tick(1);
        chk("disp_tmr", disp_d, TMR_DIG);

        // Digit pulses in TMR_SET
        t0 = tog_cnt;
        i0 = inc_cnt;
        pulse_btn(1);
        pulse_btn(2);
        pulse_btn(1);
        pulse_btn(2);
        pulse_btn(1);
        chk("set_toggle_count", tog_cnt - t0, 3);
        chk("set_inc_count", inc_cnt - i0, 2);
        chk("pulse_width", wide_cnt, 0);

        // Mode and sel together: mode wins, sel dropped, back to held SW_PAUSE
        t0 = tog_cnt;
        btn_mode = 1'b1;
        btn_sel  = 1'b1;
        tick(1);
        chk("prio_mode_led", mode_led, 0);
        btn_mode = 1'b0;
        btn_sel  = 1'b0;
        tick(1);
        chk("prio_no_toggle", tog_cnt - t0, 0);
        chk("back_disp_sw", disp_d, SW_DIG);
        short_press();
        chk("held_resume_run", sw_en, 1);
        short_press();

        // Long press in PAUSE -> IDLE; same buttons give no pulses there
        c0 = clr_cnt;
        btn_start = 1'b1;
        tick(9);
        btn_start = 1'b0;
        tick(1);
        chk("pause_long_clr", clr_cnt - c0, 1);
        t0 = tog_cnt;
        i0 = inc_cnt;
        pulse_btn(1);
        pulse_btn(1);
        pulse_btn(1);
        pulse_btn(2);
        pulse_btn(2);
        chk("idle_no_toggle", tog_cnt - t0, 0);
        chk("idle_no_inc", inc_cnt - i0, 0);

        // Timer run, times up, alarm blink, acknowledge
        pulse_btn(0);
        chk("tmr_mode_led", mode_led, 1);
        short_press();
        chk("tmr_run_en", tmr_en, 1);
        chk("tmr_run_sw_en", sw_en, 0);
        tmr_times_up = 1'b1;
        tick(1);
        tmr_times_up = 1'b0;
        chk("done_tmr_en", tmr_en, 0);
        alarm_seq[15] = alarm_led;
        for (int k = 14; k >= 0; k--) begin
            tick(1);
            alarm_seq[k] = alarm_led;
        end
        chk("alarm_pattern", alarm_seq, 16'hF0F0);
        short_press();
        chk("ack_tmr_rst", tmr_rst, 1);
        chk("ack_alarm", alarm_led, 0);
        chk("ack_mode_led", mode_led, 1);
        tick(1);
        chk("ack_tmr_rst_one_cycle", tmr_rst, 0);
        t0 = tog_cnt;
        pulse_btn(1);
        chk("ack_in_set", tog_cnt - t0, 1);

        // Reset from TMR_SET with btn_start held through release
        rst = 1'b1;
        #1;
        chk("async_rst_mode_led", mode_led, 0);
        chk("async_rst_tmr_rst", tmr_rst, 1);
        btn_start = 1'b1;
        tick(2);
        rst = 1'b0;
        c0 = clr_cnt;
        tick(12);
        chk("held_rst_no_long", clr_cnt - c0, 0);
        btn_start = 1'b0;
        tick(1);
        chk("held_rst_no_short", sw_en, 0);

        // Reset mid-hold at count 5
        btn_start = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        c0 = clr_cnt;
        tick(10);
        chk("midhold_no_long", clr_cnt - c0, 0);
        btn_start = 1'b0;
        tick(1);
        chk("midhold_no_short", sw_en, 0);
        chk("midhold_idle_led", mode_led, 0);
        short_press();
        chk("after_rst_short", sw_en, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed hang expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stopwatch_timer_ctrl.md
Name: stopwatch_timer_ctrl

Overview:
- Top-level mode controller for the stopwatch/countdown-timer board.
- Converts four debounced push-button levels into control strobes and enables for the stopwatch counter and the countdown timer.
- Sequences the run, pause and clear modes of both blocks.
- Arbitrates which block's eight BCD digits drive the shared 7-segment display, and drives the mode and alarm LEDs.

Parameters:
- HOLD_CYCLES, 100_000_000: consecutive btn_start-high cycles that count as a long press (1 s at 100 MHz).
- ALARM_CYCLES, 25_000_000: half-period of the alarm_led blink, in cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- btn_mode  in  1  debounced level; toggles between stopwatch and timer
- btn_start  in  1  debounced level; short press = start/pause, long press = clear
- btn_sel  in  1  debounced level; selects the next timer digit (TMR_SET only)
- btn_inc  in  1  debounced level; increments the selected timer digit (TMR_SET only)
- tmr_times_up  in  1  timer reached zero
- sw_d  in  32  stopwatch digits {d7..d0}, 4-bit BCD each
- tmr_d  in  32  timer digits {d7..d0}
- sw_en  out  1  stopwatch count enable
- sw_clr  out  1  stopwatch clear, 1-cycle pulse
- tmr_en  out  1  timer enable
- tmr_rst  out  1  timer reset, 1-cycle pulse
- tmr_digit_inc  out  1  1-cycle pulse
- tmr_digit_toggle  out  1  1-cycle pulse
- disp_d  out  32  digits routed to the display
- mode_led  out  1  1 = timer mode
- alarm_led  out  1  blinks in TMR_DONE

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is clk. All outputs are registered.
- Reset values:
  - state = SW_IDLE
  - sw_en, sw_clr, tmr_en, tmr_digit_inc, tmr_digit_toggle, mode_led, alarm_led = 0
  - tmr_rst = 1 while rst is high, then 0
  - disp_d = 32'hAAAA_AAAA (blank)
  - hold counter = 0, blink counter = 0, sw_held = 0
- Press detection:
  - Each button has a prev register, reset to 1, so a button held through reset release does not fire.
  - press = btn & ~prev, evaluated each posedge.
- btn_start classification:
  - The hold counter counts while btn_start = 1 and saturates at HOLD_CYCLES.
  - A long event fires once, in the cycle the counter reaches HOLD_CYCLES.
  - A short event fires on the btn_start falling edge only if the counter is below HOLD_CYCLES.
  - The counter clears when btn_start = 0.
  - The release after a long press produces nothing.
- Priority when events coincide in one cycle: start event > mode press > sel/inc press. At most one action is taken per cycle; lower-priority presses that cycle are dropped.
- FSM transitions (unlisted events are ignored):
  - SW_IDLE:
    - short -> SW_RUN
    - long -> sw_clr pulse
    - mode -> TMR_SET
  - SW_RUN (sw_en = 1):
    - short -> SW_PAUSE
    - long -> sw_clr pulse, SW_IDLE
    - mode ignored
  - SW_PAUSE:
    - short -> SW_RUN
    - long -> sw_clr pulse, SW_IDLE
    - mode -> set sw_held = 1, TMR_SET
  - TMR_SET:
    - sel press -> tmr_digit_toggle pulse
    - inc press -> tmr_digit_inc pulse
    - short -> TMR_RUN
    - long -> tmr_rst pulse
    - mode -> SW_PAUSE if sw_held, else SW_IDLE; sw_held cleared
  - TMR_RUN (tmr_en = 1):
    - short -> TMR_PAUSE
    - long -> tmr_rst pulse, TMR_SET
    - tmr_times_up -> TMR_DONE (has priority over start events)
  - TMR_PAUSE:
    - short -> TMR_RUN
    - long -> tmr_rst pulse, TMR_SET
  - TMR_DONE:
    - alarm_led toggles every ALARM_CYCLES, starting at 1 on entry.
    - short or long -> tmr_rst pulse, alarm_led = 0, TMR_SET
- Outputs in each state:
  - sw_en = 1 only in SW_RUN.
  - tmr_en = 1 only in TMR_RUN.
  - mode_led = 1 in all TMR_* states.
- Pulse and state timing: all pulses are high for exactly the one cycle after the triggering posedge, the same cycle the new state becomes visible.
- Display mux:
  - disp_d = sw_d in SW_* states, tmr_d in TMR_* states.
  - One-cycle registered latency; it follows the registered state, so it switches one cycle after mode_led.
- Reset mid-operation: everything returns immediately to the reset values. An in-progress hold is discarded and no event fires on release.

Test Plan:
- Bench parameters: HOLD_CYCLES = 8, ALARM_CYCLES = 4.
- btn_start high for 3 cycles then low, from SW_IDLE -> sw_en = 1 from the cycle after the falling edge. Repeat -> sw_en = 0 (SW_PAUSE).
- btn_start held 12 cycles in SW_RUN -> sw_clr high for exactly 1 cycle, 8 cycles after the rise; sw_en = 0. No action on release.
- From SW_PAUSE, press mode -> mode_led = 1 and, 1 cycle later, disp_d = tmr_d. Press mode again -> state SW_PAUSE (sw_held restored), disp_d = sw_d.
- In TMR_SET, 3 sel presses and 2 inc presses -> exactly 3 tmr_digit_toggle and 2 tmr_digit_inc one-cycle pulses. The same presses in SW_IDLE -> no pulses.
- TMR_RUN, then drive tmr_times_up = 1 -> tmr_en = 0, alarm_led pattern 1111000011110000. Short start -> tmr_rst pulse, alarm_led = 0, back in TMR_SET.
- btn_start held through rst deassertion -> no event. Asserting rst mid-hold at count 5 -> returns to SW_IDLE, no long event fires.
